// File: rtl/a2d_sched.sv
// a2d_sched: round-robin scheduler for the shared SPI A2D converter.
// Each nxt runs an address + read transaction on LFT, RGHT, STEER, BATT in turn.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   nxt             start one conversion (sampled only in IDLE)
//   spi_done        1-clk transaction-complete pulse from the SPI master
//   spi_rd[15:0]    SPI receive data, valid with spi_done
//   spi_wrt         1-clk pulse: start an SPI transaction with spi_cmd
//   spi_cmd[15:0]   registered command word {2'b00, chnl, 11'h000}
//   lft_ld, rght_ld, steer_pot, batt [11:0]  latest result per channel
//   upd[3:0]        one-hot {BATT,STEER,RGHT,LFT} pulse on result update
//   busy            high while a conversion is in flight
module a2d_sched #(
  parameter logic [2:0] CH_LFT   = 3'd0,
  parameter logic [2:0] CH_RGHT  = 3'd4,
  parameter logic [2:0] CH_STEER = 3'd5,
  parameter logic [2:0] CH_BATT  = 3'd6,
  parameter int         DEAD_CYC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nxt,
  input  logic        spi_done,
  input  logic [15:0] spi_rd,
  output logic        spi_wrt,
  output logic [15:0] spi_cmd,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic [3:0]  upd,
  output logic        busy
);

  localparam int CW = $clog2(DEAD_CYC + 1);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DEAD,
    READ
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [1:0]    ptr;
  logic [CW-1:0] cnt;
  logic [2:0]    chnl;
  logic          dead_last;
  logic          wrt_set;
  logic          dead_ld;
  logic          rd_ld;

  // Upper result nibble carries no conversion data.
  logic          unused_rd;
  assign unused_rd = ^spi_rd[15:12];

  always_comb begin
    chnl = CH_LFT;
    unique case (ptr)
      2'd0: chnl = CH_LFT;
      2'd1: chnl = CH_RGHT;
      2'd2: chnl = CH_STEER;
      2'd3: chnl = CH_BATT;
      default: chnl = CH_LFT;
    endcase
  end

  assign dead_last = (cnt == CW'(1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; spi_done outside ADDR/READ is ignored
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (nxt)       state_nxt = ADDR;
      ADDR: if (spi_done)  state_nxt = DEAD;
      DEAD: if (dead_last) state_nxt = READ;
      READ: if (spi_done)  state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  // Output / strobe decode
  always_comb begin
    wrt_set = 1'b0;
    dead_ld = 1'b0;
    rd_ld   = 1'b0;
    unique case (1'b1)
      (state == IDLE): wrt_set = nxt;
      (state == ADDR): dead_ld = spi_done;
      (state == DEAD): wrt_set = dead_last;
      (state == READ): rd_ld   = spi_done;
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

  // Datapath: command, dead counter, results, pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_wrt   <= 1'b0;
      spi_cmd   <= '0;
      cnt       <= '0;
      ptr       <= '0;
      upd       <= '0;
      lft_ld    <= '0;
      rght_ld   <= '0;
      steer_pot <= '0;
      batt      <= '0;
    end else begin
      spi_wrt <= wrt_set;
      upd     <= '0;
      if (wrt_set)
        spi_cmd <= {2'b00, chnl, 11'h000};
      if (dead_ld)
        cnt <= CW'(DEAD_CYC);
      else if (state == DEAD)
        cnt <= cnt - CW'(1);
      if (rd_ld) begin
        upd <= 4'b0001 << ptr;
        ptr <= ptr + 2'd1;
        unique case (ptr)
          2'd0: lft_ld    <= spi_rd[11:0];
          2'd1: rght_ld   <= spi_rd[11:0];
          2'd2: steer_pot <= spi_rd[11:0];
          2'd3: batt      <= spi_rd[11:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_a2d_sched.sv
// tb_a2d_sched: scoreboard bench for a2d_sched.
// Driver queues expected commands/updates; a negedge monitor checks them.
module tb_a2d_sched;

  localparam int DEAD_CYC = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        nxt = 1'b0;
  logic        spi_done = 1'b0;
  logic [15:0] spi_rd = '0;
  logic        spi_wrt;
  logic [15:0] spi_cmd;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic [11:0] steer_pot;
  logic [11:0] batt;
  logic [3:0]  upd;
  logic        busy;

  always #5 clk = ~clk;

  a2d_sched #(
    .CH_LFT   (3'd0),
    .CH_RGHT  (3'd4),
    .CH_STEER (3'd5),
    .CH_BATT  (3'd6),
    .DEAD_CYC (DEAD_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .nxt       (nxt),
    .spi_done  (spi_done),
    .spi_rd    (spi_rd),
    .spi_wrt   (spi_wrt),
    .spi_cmd   (spi_cmd),
    .lft_ld    (lft_ld),
    .rght_ld   (rght_ld),
    .steer_pot (steer_pot),
    .batt      (batt),
    .upd       (upd),
    .busy      (busy)
  );

  typedef struct packed {
    logic [3:0]       upd;
    logic [3:0][11:0] r;
  } exp_t;

  logic [15:0]      cmd_q[$];
  exp_t             upd_q[$];
  int               n_chk = 0;
  int               n_fail = 0;
  logic [2:0]       ch_tab[4] = '{3'd0, 3'd4, 3'd5, 3'd6};
  logic [3:0][11:0] mreg = '0;
  int               mptr = 0;
  logic [3:0][11:0] dregs;
  logic             prev_wrt = 1'b0;

  assign dregs = {batt, steer_pot, rght_ld, lft_ld};

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every spi_wrt and upd must match the queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (spi_wrt) begin
      chk("wrt_back_to_back", 32'(prev_wrt), 32'd0);
      n_chk++;
      if (cmd_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexp_wrt: spi_cmd=%h, none expected", spi_cmd);
      end else begin
        n_chk--;
        chk("spi_cmd", 32'(spi_cmd), 32'(cmd_q.pop_front()));
      end
    end
    prev_wrt = spi_wrt;
    if (upd != 4'b0000) begin
      n_chk++;
      if (upd_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexp_upd: upd=%b, none expected", upd);
      end else begin
        n_chk--;
        e = upd_q.pop_front();
        chk("upd", 32'(upd), 32'(e.upd));
        for (int i = 0; i < 4; i++)
          chk($sformatf("reg%0d", i), 32'(dregs[i]), 32'(e.r[i]));
      end
    end
  end

  task automatic chk_zero(input string nm);
    chk({nm, "_wrt"}, 32'(spi_wrt), 32'd0);
    chk({nm, "_cmd"}, 32'(spi_cmd), 32'd0);
    chk({nm, "_upd"}, 32'(upd), 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_reg%0d", nm, i), 32'(dregs[i]), 32'd0);
  endtask

  // One conversion. Entered either just after a posedge or at a negedge.
  task automatic conv(input logic [15:0] rd, input bit stray,
                      input bit spam, input bit keep);
    int n;
    logic [15:0] c;
    c = {2'b00, ch_tab[mptr], 11'h000};
    if (stray) begin
      spi_done = 1'b1;
      spi_rd = 16'($urandom);
      @(posedge clk);
      #1 spi_done = 1'b0;
      @(negedge clk);
      chk("idle_stray_busy", 32'(busy), 32'd0);
    end
    cmd_q.push_back(c);
    cmd_q.push_back(c);
    nxt = 1'b1;
    @(posedge clk);
    #1 nxt = keep;
    @(negedge clk);
    chk("start_wrt", 32'(spi_wrt), 32'd1);
    chk("start_busy", 32'(busy), 32'd1);
    n = $urandom_range(0, 3);
    repeat (n) begin
      if (spam) nxt = 1'($urandom);
      @(negedge clk);
    end
    spi_done = 1'b1;
    spi_rd = 16'($urandom);
    if (spam) nxt = 1'b1;
    @(posedge clk);
    #1 spi_done = 1'b0;
    nxt = keep;
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (spi_wrt || n >= 50) break;
      spi_done = stray && (n == 2);
      spi_rd = 16'($urandom);
      nxt = spam ? 1'($urandom) : keep;
    end
    spi_done = 1'b0;
    chk("dead_len", 32'(n), 32'(DEAD_CYC + 1));
    n = $urandom_range(0, 3);
    repeat (n) @(negedge clk);
    chk("read_busy", 32'(busy), 32'd1);
    mreg[mptr] = rd[11:0];
    upd_q.push_back('{upd: 4'(1 << mptr), r: mreg});
    mptr = (mptr + 1) % 4;
    spi_done = 1'b1;
    spi_rd = rd;
    nxt = spam ? 1'b1 : keep;
    @(posedge clk);
    #1 spi_done = 1'b0;
    spi_rd = 16'($urandom);
    nxt = keep;
    @(negedge clk);
    chk("end_busy", 32'(busy), 32'd0);
  endtask

  // Reset in the DEAD phase of the current conversion
  task automatic reset_mid();
    cmd_q.push_back({2'b00, ch_tab[mptr], 11'h000});
    nxt = 1'b1;
    @(posedge clk);
    #1 nxt = 1'b0;
    @(negedge clk);
    spi_done = 1'b1;
    spi_rd = 16'($urandom);
    @(posedge clk);
    #1 spi_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1 chk_zero("mid_rst");
    mreg = '0;
    mptr = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    chk_zero("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    conv(16'hFABC, 0, 0, 0);
    conv(16'h3111, 0, 0, 0);
    conv(16'hA222, 0, 0, 0);
    conv(16'h5333, 0, 0, 0);
    conv(16'hF444, 0, 0, 0);
    conv(16'($urandom), 0, 0, 0);
    conv(16'($urandom), 1, 1, 0);
    for (int i = 0; i < 12; i++)
      conv(16'($urandom), 1'($urandom), 1'($urandom), 0);
    while (mptr != 1) conv(16'($urandom), 0, 0, 0);
    reset_mid();
    conv(16'($urandom), 0, 0, 0);
    conv(16'($urandom), 0, 0, 1);
    conv(16'($urandom), 0, 0, 1);
    conv(16'($urandom), 0, 0, 0);
    repeat (8) @(negedge clk);
    chk("cmd_q_empty", 32'(cmd_q.size()), 32'd0);
    chk("upd_q_empty", 32'(upd_q.size()), 32'd0);
    chk("final_busy", 32'(busy), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
